// File: rtl/fp_align_swap_pipe.sv
// fp_align_swap_pipe
//   Two-stage operand order/align pipe for the FP add/sub datapath.
//   Stage 1 unpacks both operands, applies the subtract sign flip to B and
//   routes the larger magnitude to the "l" path.
//   Stage 2 right-shifts the smaller significand by the exponent difference.
//   The shift saturates at SIG_W, and every bit shifted out is folded into
//   the sticky bit (bit 0).
//
// Ports
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   operand handshake (in_ready is combinational from out_ready)
//   op_a, op_b, sub     operands {sign, exp, frac}; sub=1 computes A-B
//   out_valid/out_ready result handshake
//   sign_l, sign_s      signs of the larger / smaller magnitude operand
//   exp_l               effective exponent of the larger operand
//   sig_l               {hidden, frac, 3'b000} of the larger operand
//   sig_s               aligned smaller significand {bits, G, R, S}
//   eff_sub             sign_l ^ sign_s
//   swapped             B was routed to the large path
module fp_align_swap_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int SIG_W = MAN_W + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign_l,
  output logic                   sign_s,
  output logic [EXP_W-1:0]       exp_l,
  output logic [SIG_W-1:0]       sig_l,
  output logic [SIG_W-1:0]       sig_s,
  output logic                   eff_sub,
  output logic                   swapped
);

  localparam int STAGES = 2;
  localparam int OP_W   = 1 + EXP_W + MAN_W;
  localparam int SH_W   = $clog2(SIG_W + 1);

  typedef struct packed {
    logic             sign_l;
    logic             sign_s;
    logic [EXP_W-1:0] exp_l;
    logic [MAN_W:0]   sig_l;
    logic [MAN_W:0]   sig_s;
    logic [EXP_W-1:0] shift;
    logic             swapped;
  } s1_t;

  typedef struct packed {
    logic             sign_l;
    logic             sign_s;
    logic [EXP_W-1:0] exp_l;
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;
    logic             eff_sub;
    logic             swapped;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic            s1_adv, s2_adv;

  // ---------------- handshake ----------------
  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = vld_pipe[2];

  // ---------------- stage 1: unpack + compare/swap ----------------
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp, a_exp_eff, b_exp_eff;
  logic [MAN_W:0]   a_sig, b_sig;
  logic [EXP_W:0]   diff, neg_diff;
  logic             do_swap;

  always_comb begin
    a_sign    = op_a[OP_W-1];
    b_sign    = op_b[OP_W-1] ^ sub;
    a_exp     = op_a[OP_W-2 -: EXP_W];
    b_exp     = op_b[OP_W-2 -: EXP_W];
    // exp==0 is denormal/zero: no hidden bit, exponent behaves as 1
    a_exp_eff = (a_exp == '0) ? EXP_W'(1) : a_exp;
    b_exp_eff = (b_exp == '0) ? EXP_W'(1) : b_exp;
    a_sig     = {(a_exp != '0), op_a[MAN_W-1:0]};
    b_sig     = {(b_exp != '0), op_b[MAN_W-1:0]};
    diff      = {1'b0, a_exp_eff} - {1'b0, b_exp_eff};
    neg_diff  = -diff;
    // borrow means B has the larger exponent; equal magnitudes keep A large
    do_swap   = diff[EXP_W] || ((diff == '0) && (b_sig > a_sig));

    s1_d.swapped = do_swap;
    s1_d.shift   = diff[EXP_W] ? neg_diff[EXP_W-1:0] : diff[EXP_W-1:0];
    if (do_swap) begin
      s1_d.sign_l = b_sign;
      s1_d.sign_s = a_sign;
      s1_d.exp_l  = b_exp_eff;
      s1_d.sig_l  = b_sig;
      s1_d.sig_s  = a_sig;
    end else begin
      s1_d.sign_l = a_sign;
      s1_d.sign_s = b_sign;
      s1_d.exp_l  = a_exp_eff;
      s1_d.sig_l  = a_sig;
      s1_d.sig_s  = b_sig;
    end
  end

  // ---------------- stage 2: align with sticky ----------------
  logic [SH_W-1:0]  shift_eff;
  logic [SIG_W-1:0] full_s, shifted;
  logic [SIG_W:0]   lost_mask;
  logic             sticky;

  always_comb begin
    if (32'(s1_q.shift) >= SIG_W) shift_eff = SH_W'(SIG_W);
    else                          shift_eff = SH_W'(s1_q.shift);
    full_s    = {s1_q.sig_s, 3'b000};
    shifted   = full_s >> shift_eff;
    // one extra bit so a full-width shift still yields an all-ones mask
    lost_mask = ((SIG_W+1)'(1) << shift_eff) - (SIG_W+1)'(1);
    sticky    = |(full_s & lost_mask[SIG_W-1:0]);

    s2_d.sign_l  = s1_q.sign_l;
    s2_d.sign_s  = s1_q.sign_s;
    s2_d.exp_l   = s1_q.exp_l;
    s2_d.sig_l   = {s1_q.sig_l, 3'b000};
    s2_d.sig_s   = {shifted[SIG_W-1:1], shifted[0] | sticky};
    s2_d.eff_sub = s1_q.sign_l ^ s1_q.sign_s;
    s2_d.swapped = s1_q.swapped;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
    end
  end

  assign sign_l  = s2_q.sign_l;
  assign sign_s  = s2_q.sign_s;
  assign exp_l   = s2_q.exp_l;
  assign sig_l   = s2_q.sig_l;
  assign sig_s   = s2_q.sig_s;
  assign eff_sub = s2_q.eff_sub;
  assign swapped = s2_q.swapped;

endmodule

// File: tb/tb_fp_align_swap_pipe.sv
// Scoreboard bench for fp_align_swap_pipe (default single-precision params).
module tb_fp_align_swap_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready, sub;
  logic [31:0] op_a, op_b;
  logic        out_valid, out_ready;
  logic        sign_l, sign_s, eff_sub, swapped;
  logic [7:0]  exp_l;
  logic [26:0] sig_l, sig_s;

  fp_align_swap_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_l(sign_l), .sign_s(sign_s), .exp_l(exp_l),
    .sig_l(sig_l), .sig_s(sig_s), .eff_sub(eff_sub), .swapped(swapped)
  );

  typedef struct packed {
    logic        sign_l;
    logic        sign_s;
    logic [7:0]  exp_l;
    logic [26:0] sig_l;
    logic [26:0] sig_s;
    logic        eff_sub;
    logic        swapped;
  } exp_t;

  typedef struct {
    exp_t e;
    int   idx;
    int   acc;
    bit   lat;
  } sb_t;

  sb_t         q[$];
  int          n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] va[10], vb[10];
  logic        vs[10];
  exp_t        ve[10];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic sl, input logic ss, input logic [7:0] el,
                              input logic [26:0] gl, input logic [26:0] gs,
                              input logic eff, input logic sw);
    exp_t r;
    r.sign_l = sl; r.sign_s = ss; r.exp_l = el; r.sig_l = gl;
    r.sig_s = gs; r.eff_sub = eff; r.swapped = sw;
    return r;
  endfunction

  // Monitor: compares the head of the scoreboard whenever output is valid;
  // while stalled this also proves the held data is unchanged.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t got;
        got = {sign_l, sign_s, exp_l, sig_l, sig_s, eff_sub, swapped};
        chk($sformatf("result_v%0d", q[0].idx), got, q[0].e);
        if (out_ready) begin
          if (q[0].lat) chk($sformatf("latency_v%0d", q[0].idx), cyc - q[0].acc, 2);
          void'(q.pop_front());
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after acceptance.
  task automatic send(input int i, input bit lat);
    bit ok = 0;
    in_valid = 1; op_a = va[i]; op_b = vb[i]; sub = vs[i];
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_t s;
        s.e = ve[i]; s.idx = i; s.acc = cyc; s.lat = lat;
        q.push_back(s);
        ok = 1;
        break;
      end
    end
    if (!ok) chk($sformatf("accept_timeout_v%0d", i), 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 40; t++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    va[0]=32'h3F800000; vb[0]=32'h40000000; vs[0]=0; ve[0]=mk(0,0,8'h80,27'h4000000,27'h2000000,0,1);
    va[1]=32'h3F800000; vb[1]=32'h3FC00000; vs[1]=1; ve[1]=mk(1,0,8'h7F,27'h6000000,27'h4000000,1,1);
    va[2]=32'h4B800000; vb[2]=32'h3F800000; vs[2]=0; ve[2]=mk(0,0,8'h97,27'h4000000,27'h0000004,0,0);
    va[3]=32'h7F000000; vb[3]=32'h3F800001; vs[3]=0; ve[3]=mk(0,0,8'hFE,27'h4000000,27'h0000001,0,0);
    va[4]=32'h00000001; vb[4]=32'h00000000; vs[4]=0; ve[4]=mk(0,0,8'h01,27'h0000008,27'h0000000,0,0);
    va[5]=32'h40400000; vb[5]=32'h40400000; vs[5]=1; ve[5]=mk(0,1,8'h80,27'h6000000,27'h6000000,1,0);
    va[6]=32'h41800000; vb[6]=32'h3F800001; vs[6]=0; ve[6]=mk(0,0,8'h83,27'h4000000,27'h0400001,0,0);
    va[7]=32'h3F800000; vb[7]=32'hC0000000; vs[7]=1; ve[7]=mk(0,0,8'h80,27'h4000000,27'h2000000,0,1);
    va[8]=32'h4C000000; vb[8]=32'h3F800000; vs[8]=0; ve[8]=mk(0,0,8'h98,27'h4000000,27'h0000002,0,0);
    va[9]=32'h4D000000; vb[9]=32'h3F800000; vs[9]=0; ve[9]=mk(0,0,8'h9A,27'h4000000,27'h0000001,0,0);

    rst = 1; in_valid = 0; op_a = 0; op_b = 0; sub = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", {sign_l, sign_s, exp_l, sig_l, sig_s, eff_sub, swapped}, 0);
    rst = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // directed vectors, back-to-back, full throughput, exact latency
    for (int i = 0; i < 10; i++) send(i, 1);
    drain("drain_directed");

    // backpressure: 3-cycle stall starting at the first out_valid
    fork
      begin
        for (int i = 0; i < 4; i++) send(i, 0);
      end
      begin
        bit seen = 0;
        for (int t = 0; t < 20; t++) begin
          @(posedge clk); #1;
          if (out_valid) begin seen = 1; break; end
        end
        chk("bp_first_valid", seen, 1);
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_out_valid_held", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain("drain_backpressure");

    // async reset with both stages full
    out_ready = 0;
    send(5, 0);
    send(6, 0);
    #2;
    rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_data", {sign_l, sign_s, exp_l, sig_l, sig_s, eff_sub, swapped}, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send(2, 1);
    drain("drain_after_reset");
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
